// File: rtl/ram_bist_pkg.sv
// Shared definitions for the ram_bist march-test initiator: FSM state
// encoding and default geometry / data pattern.
package ram_bist_pkg;

  localparam int         DEF_AW      = 8;
  localparam int         DEF_DW      = 4;
  localparam int         DEF_CW      = 8;
  localparam logic [3:0] DEF_PATTERN = 4'b0101;

  typedef enum logic [2:0] {
    IDLE,
    WR0,
    RD0,
    WR1,
    RD1,
    FIN
  } state_t;

endpackage

// File: rtl/ram_bist_cmp.sv
// One-stage read-compare pipeline for ram_bist. It captures the address and
// expected value of each read. It then compares them with the RAM's registered
// read data one cycle later. It reports a mismatch pulse and the failing
// address. It keeps no run state, so the FSM may move on while it drains.
module ram_bist_cmp #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] exp_in,
  input  logic [DW-1:0] d_o,
  output logic          mismatch,
  output logic [AW-1:0] addr
);

  logic          vld_q;
  logic [DW-1:0] exp_q;

  // Delay each read's address/expected value to line up with the RAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      addr  <= '0;
      exp_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, so ordering inside the block cannot create races.
      vld_q <= push;
      addr  <= addr_in;
      exp_q <= exp_in;
    end
  end

  assign mismatch = vld_q && (d_o != exp_q);

endmodule

// File: rtl/ram_bist.sv
// ram_bist: four-phase march self-test (write P, read P, write ~P, read ~P)
// for a single-port RAM with registered read data.
// Optional feature: define RAM_BIST_ABORT_EN to end the test at the first
// mismatch; the default build always runs the full march.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int            AW      = DEF_AW,
  parameter int            DW      = DEF_DW,
  parameter int            CW      = DEF_CW,
  parameter logic [DW-1:0] PATTERN = DW'(DEF_PATTERN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [CW-1:0] err_count,
  output logic          w,
  output logic          r,
  output logic [AW-1:0] ad,
  output logic [DW-1:0] d_i,
  input  logic [DW-1:0] d_o
);

  state_t        state, state_n;
  logic          w_n, r_n, busy_n, done_n;
  logic [AW-1:0] ad_n;
  logic [DW-1:0] d_i_n;

  logic          mismatch;
  logic [AW-1:0] cmp_addr;
  logic          cnt_en, hit, accept, last;
  logic [CW-1:0] err_next;

  ram_bist_cmp #(.AW(AW), .DW(DW)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .push     (r),
    .addr_in  (ad),
    .exp_in   ((state == RD1) ? ~PATTERN : PATTERN),
    .d_o      (d_o),
    .mismatch (mismatch),
    .addr     (cmp_addr)
  );

`ifdef RAM_BIST_ABORT_EN
  // Only the first mismatch is counted; it also aborts the march.
  assign cnt_en = (err_count == '0);
`else
  assign cnt_en = 1'b1;
`endif

  assign hit    = mismatch && cnt_en;
  assign accept = (state == IDLE) && start;
  assign last   = (ad == {AW{1'b1}});

  // Saturating error count including this cycle's compare result.
  always_comb begin
    err_next = err_count;
    if (hit && (err_count != {CW{1'b1}})) err_next = err_count + CW'(1);
  end

  // Next state and next values of the registered RAM/handshake outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_n = state;
    w_n     = 1'b0;
    r_n     = 1'b0;
    ad_n    = ad;
    d_i_n   = d_i;
    busy_n  = busy;
    done_n  = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        state_n = WR0;
        w_n     = 1'b1;
        ad_n    = '0;
        d_i_n   = PATTERN;
        busy_n  = 1'b1;
      end
      WR0: if (last) begin
        state_n = RD0; r_n = 1'b1; ad_n = '0; d_i_n = '0;
      end else begin
        w_n = 1'b1; ad_n = ad + AW'(1);
      end
      RD0: if (last) begin
        state_n = WR1; w_n = 1'b1; ad_n = '0; d_i_n = ~PATTERN;
      end else begin
        r_n = 1'b1; ad_n = ad + AW'(1);
      end
      WR1: if (last) begin
        state_n = RD1; r_n = 1'b1; ad_n = '0; d_i_n = '0;
      end else begin
        w_n = 1'b1; ad_n = ad + AW'(1);
      end
      RD1: if (last) begin
        state_n = FIN; ad_n = '0;
      end else begin
        r_n = 1'b1; ad_n = ad + AW'(1);
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
`ifdef RAM_BIST_ABORT_EN
    if (hit && (state inside {WR0, RD0, WR1, RD1})) begin
      state_n = FIN;
      w_n     = 1'b0;
      r_n     = 1'b0;
      ad_n    = '0;
      d_i_n   = '0;
    end
`endif
  end

  // State register and registered RAM/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      w     <= 1'b0;
      r     <= 1'b0;
      ad    <= '0;
      d_i   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      w     <= w_n;
      r     <= r_n;
      ad    <= ad_n;
      d_i   <= d_i_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Result registers: clear on start, count mismatches, capture first fail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_count <= '0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      err_count <= err_next;
      if (hit && (err_count == '0)) fail_addr <= cmp_addr;
      if (state == FIN) pass <= (err_next == '0);
    end
  end

endmodule
